// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the UART instruction-memory loader.
// The frame FSM and the UART receiver both import this package.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DATA  = 2'd2,
      ST_CSUM  = 2'd3
   } load_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   localparam int         DEF_CLKS_PER_BIT = 434;
   localparam int         DEF_GAP_CYCLES   = 5000000;
   localparam logic [7:0] DEF_HDR_BYTE     = 8'hA5;

   // A count byte of zero stands for a full 256-word image.
   function automatic logic [8:0] word_count(input logic [7:0] n);
      return (n == 8'd0) ? 9'd256 : {1'b0, n};
   endfunction

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, times each bit from the start-bit
// centre and reports one byte_valid pulse or one frame_err pulse per byte.
module uart_rx
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rxd_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1_q, sync2_q, prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   // Synchronizer and edge-detect flops idle high like the line itself.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         // A start bit that is high again at its centre was only a glitch.
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = sync2_q;
               ferr_d  = !sync2_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign byte_valid_o = valid_q;
   assign byte_data_o  = shift_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image over UART and writes it word by word into
// instruction memory, holding the CPU while a frame is in flight.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int         GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter logic [7:0] HDR_BYTE     = DEF_HDR_BYTE
) (
   input  logic        CCLK,
   input  logic        reset_n,
   input  logic        rxd,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [8:0]  words_loaded
);

   localparam int            GW       = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk_i       (CCLK),
      .rst_ni      (reset_n),
      .rxd_i       (rxd),
      .byte_valid_o(byte_valid),
      .byte_data_o (byte_data),
      .frame_err_o (frame_err)
   );

   load_state_e   state_q, state_d;
   logic [8:0]    count_q, count_d;
   logic [23:0]   word_q, word_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [7:0]    word_idx_q, word_idx_d;
   logic [8:0]    loaded_q, loaded_d;
   logic [7:0]    csum_q, csum_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [7:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          abort;

   always_ff @(posedge CCLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         word_q     <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         loaded_q   <= '0;
         csum_q     <= '0;
         gap_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         loaded_q   <= loaded_d;
         csum_q     <= csum_d;
         gap_q      <= gap_d;
         done_q     <= done_d;
         err_q      <= err_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   // A completed byte takes priority over an expiring gap timer.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      loaded_d   = loaded_q;
      csum_d     = csum_q;
      gap_d      = gap_q;
      done_d     = done_q;
      err_d      = err_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      abort      = 1'b0;

      if (state_q == ST_IDLE) begin
         if (byte_valid && byte_data == HDR_BYTE) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            loaded_d   = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            gap_d      = '0;
            state_d    = ST_COUNT;
         end
      end else if (frame_err) begin
         abort = 1'b1;
      end else if (byte_valid) begin
         gap_d = '0;
         case (state_q)
            ST_COUNT: begin
               count_d = word_count(byte_data);
               state_d = ST_DATA;
            end
            ST_DATA: begin
               csum_d     = csum_q ^ byte_data;
               word_d     = {word_q[15:0], byte_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = word_idx_q;
                  wdata_d    = {word_q, byte_data};
                  word_idx_d = word_idx_q + 8'd1;
                  loaded_d   = loaded_q + 9'd1;
                  if (loaded_q + 9'd1 == count_q) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (byte_data == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (gap_q == GAP_LAST) begin
         abort = 1'b1;
      end else begin
         gap_d = gap_q + 1'b1;
      end

      if (abort) begin
         state_d    = ST_IDLE;
         err_d      = 1'b1;
         byte_idx_d = '0;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign busy         = (state_q != ST_IDLE);
   assign cpu_hold     = (state_q != ST_IDLE);
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, directed corner
// cases and random frames checked against a frame-level reference model.
module tb_imem_loader;

   // The smallest legal bit period keeps the 1024-byte frame short.
   localparam int         CPB = 8;
   localparam int         GAP = 2000;
   localparam logic [7:0] HDR = 8'hA5;

   logic        CCLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        rxd = 1'b1;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [8:0]  words_loaded;

   always #5 CCLK = ~CCLK;

   imem_loader #(
      .CLKS_PER_BIT(CPB),
      .GAP_CYCLES  (GAP),
      .HDR_BYTE    (HDR)
   ) dut (
      .CCLK        (CCLK),
      .reset_n     (reset_n),
      .rxd         (rxd),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .words_loaded(words_loaded)
   );

   typedef struct {
      logic [95:0] stream;
      int          len;
      int          nWr;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        expDone;
      logic        expErr;
      logic [8:0]  expWords;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic [39:0] wrQ[$];
   logic [39:0] expW[$];
   logic [7:0]  sB[$];
   int          sK[$];
   logic        expDone;
   logic        expErr;
   logic [8:0]  expWords;

   // Every write strobe is logged as {addr, data}.
   always @(negedge CCLK) begin
      if (imem_we) wrQ.push_back({imem_addr, imem_wdata});
   end

   initial begin
      repeat (120000) @(posedge CCLK);
      $display("[TB] FAIL watchdog: run still active after 120000 cycles, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      rxd = 1'b0;
      repeat (CPB) @(negedge CCLK);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge CCLK);
      end
      rxd = stopBit;
      repeat (CPB) @(negedge CCLK);
      rxd = 1'b1;
      if (!stopBit) repeat (CPB) @(negedge CCLK);
   endtask

   task automatic glitch();
      rxd = 1'b0;
      repeat (3) @(negedge CCLK);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge CCLK);
   endtask

   // Kind 0 = good byte, 1 = byte with stop bit 0, 2 = 3-cycle glitch.
   task automatic pushB(input logic [7:0] b, input int k);
      sB.push_back(b);
      sK.push_back(k);
   endtask

   task automatic clearAll();
      sB.delete();
      sK.delete();
      wrQ.delete();
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < sB.size(); i++) begin
         if (sK[i] == 2) glitch();
         else sendByte(sB[i], sK[i] == 0);
      end
      repeat (3 * CPB) @(negedge CCLK);
   endtask

   // Frame-level reading of the byte stream: find the header, take N words of
   // four big-endian bytes, then compare the checksum against their XOR.
   task automatic modelStream();
      logic [7:0]  b[$];
      int          k[$];
      int          i = 0;
      int          nWords = 0;
      logic [7:0]  x = 8'h00;
      logic [31:0] w = 32'h0;
      expW.delete();
      foreach (sB[j]) begin
         if (sK[j] != 2) begin
            b.push_back(sB[j]);
            k.push_back(sK[j]);
         end
      end
      while (i < b.size() && !(k[i] == 0 && b[i] == HDR)) i++;
      if (i >= b.size()) return;
      expDone = 1'b0;
      expErr = 1'b0;
      expWords = 9'd0;
      i++;
      if (i >= b.size()) return;
      if (k[i] != 0) begin expErr = 1'b1; return; end
      nWords = (b[i] == 8'd0) ? 256 : int'(b[i]);
      i++;
      for (int wd = 0; wd < nWords; wd++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            if (i >= b.size()) return;
            if (k[i] != 0) begin expErr = 1'b1; return; end
            w = (w << 8) | {24'h0, b[i]};
            x = x ^ b[i];
            i++;
         end
         expW.push_back({8'(wd), w});
         expWords = 9'(wd + 1);
      end
      if (i >= b.size()) return;
      if (k[i] != 0 || b[i] != x) expErr = 1'b1;
      else expDone = 1'b1;
   endtask

   task automatic compareWithModel(input string tag);
      modelStream();
      checkOutput({tag, " write count"}, 64'(wrQ.size()), 64'(expW.size()));
      for (int i = 0; i < expW.size() && i < wrQ.size(); i++)
         checkOutput({tag, " write"}, 64'(wrQ[i]), 64'(expW[i]));
      checkOutput({tag, " done"}, 64'(done), 64'(expDone));
      checkOutput({tag, " err"}, 64'(err), 64'(expErr));
      checkOutput({tag, " words_loaded"}, 64'(words_loaded), 64'(expWords));
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " cpu_hold"}, 64'(cpu_hold), 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " imem_we"}, 64'(imem_we), 64'd0);
      checkOutput({tag, " imem_addr"}, 64'(imem_addr), 64'd0);
      checkOutput({tag, " imem_wdata"}, 64'(imem_wdata), 64'd0);
      checkOutput({tag, " cpu_hold"}, 64'(cpu_hold), 64'd0);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " done"}, 64'(done), 64'd0);
      checkOutput({tag, " err"}, 64'(err), 64'd0);
      checkOutput({tag, " words_loaded"}, 64'(words_loaded), 64'd0);
   endtask

   initial begin
      vec_t        vecs[4];
      int          waited;
      int          n;
      int          badAt;
      logic [7:0]  x;
      logic [7:0]  b;
      logic [31:0] lastW;

      // Bytes are left-aligned in the stream field, first byte in the top octet.
      vecs[0] = '{stream: 96'hA5022008_00058C09_0004AC00, len: 11, nWr: 2,
                  w0: 32'h20080005, w1: 32'h8C090004, expDone: 1'b1, expErr: 1'b0, expWords: 9'd2};
      vecs[1] = '{stream: 96'hA5022008_00058C09_00040000, len: 11, nWr: 2,
                  w0: 32'h20080005, w1: 32'h8C090004, expDone: 1'b0, expErr: 1'b1, expWords: 9'd2};
      // XOR of DE AD BE EF is 8'h22.
      vecs[2] = '{stream: 96'h3CFFA501_DEADBEEF_22000000, len: 9, nWr: 1,
                  w0: 32'hDEADBEEF, w1: 32'h0, expDone: 1'b1, expErr: 1'b0, expWords: 9'd1};
      vecs[3] = '{stream: 96'h3CFFA501_DEADBEEF_42000000, len: 9, nWr: 1,
                  w0: 32'hDEADBEEF, w1: 32'h0, expDone: 1'b0, expErr: 1'b1, expWords: 9'd1};

      reset_n = 1'b0;
      rxd = 1'b1;
      repeat (3) @(negedge CCLK);
      checkAllZero("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge CCLK);

      for (int v = 0; v < 4; v++) begin
         clearAll();
         for (int i = 0; i < vecs[v].len; i++) pushB(vecs[v].stream[95 - 8 * i -: 8], 0);
         applyStimulus();
         checkOutput("table write count", 64'(wrQ.size()), 64'(vecs[v].nWr));
         if (wrQ.size() > 0) checkOutput("table word0", 64'(wrQ[0]), {24'h0, 8'd0, vecs[v].w0});
         if (vecs[v].nWr > 1 && wrQ.size() > 1)
            checkOutput("table word1", 64'(wrQ[1]), {24'h0, 8'd1, vecs[v].w1});
         lastW = (vecs[v].nWr == 2) ? vecs[v].w1 : vecs[v].w0;
         checkOutput("table hold wdata", 64'(imem_wdata), 64'(lastW));
         checkOutput("table done", 64'(done), 64'(vecs[v].expDone));
         checkOutput("table err", 64'(err), 64'(vecs[v].expErr));
         checkOutput("table words_loaded", 64'(words_loaded), 64'(vecs[v].expWords));
         checkOutput("table cpu_hold", 64'(cpu_hold), 64'd0);
         checkOutput("table busy", 64'(busy), 64'd0);
      end

      // Glitch in IDLE and another inside a word must not create bytes.
      clearAll();
      pushB(8'h00, 2);
      pushB(HDR, 0); pushB(8'h01, 0); pushB(8'h11, 0); pushB(8'h22, 0);
      pushB(8'h00, 2);
      pushB(8'h33, 0); pushB(8'h44, 0); pushB(8'h44, 0);
      applyStimulus();
      compareWithModel("glitch");

      // Silence mid-word: timeout abort, partial word dropped.
      clearAll();
      pushB(HDR, 0); pushB(8'h01, 0); pushB(8'h11, 0); pushB(8'h22, 0);
      applyStimulus();
      checkOutput("timeout busy before", 64'(busy), 64'd1);
      checkOutput("timeout cpu_hold before", 64'(cpu_hold), 64'd1);
      waited = 0;
      while (busy && waited < GAP + 200) begin
         @(negedge CCLK);
         waited++;
      end
      checkOutput("timeout busy released", 64'(busy), 64'd0);
      checkOutput("timeout cpu_hold released", 64'(cpu_hold), 64'd0);
      checkOutput("timeout timing", 64'(waited > GAP - 60 && waited <= GAP), 64'd1);
      checkOutput("timeout err", 64'(err), 64'd1);
      checkOutput("timeout done", 64'(done), 64'd0);
      checkOutput("timeout writes", 64'(wrQ.size()), 64'd0);
      checkOutput("timeout words_loaded", 64'(words_loaded), 64'd0);

      // Bad stop bit during DATA; the trailing bytes arrive while IDLE.
      clearAll();
      pushB(HDR, 0); pushB(8'h02, 0);
      pushB(8'h11, 0); pushB(8'h22, 0); pushB(8'h33, 0); pushB(8'h44, 0);
      pushB(8'h55, 1); pushB(8'h66, 0); pushB(8'h77, 0);
      applyStimulus();
      compareWithModel("frame_err");

      for (int t = 0; t < 4; t++) begin
         clearAll();
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h5A;
            pushB(b, ($urandom_range(0, 3) == 0) ? 1 : 0);
         end
         pushB(HDR, 0);
         n = $urandom_range(1, 3);
         pushB(8'(n), 0);
         badAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
         x = 8'h00;
         for (int d = 0; d < 4 * n; d++) begin
            b = 8'($urandom_range(0, 255));
            if (d == badAt) begin
               pushB(b, 1);
               break;
            end
            pushB(b, 0);
            x = x ^ b;
         end
         if (badAt < 0)
            pushB(($urandom_range(0, 1) == 1) ? x : x ^ 8'($urandom_range(1, 255)), 0);
         applyStimulus();
         compareWithModel("random");
      end

      // Asynchronous reset in the middle of the second word.
      clearAll();
      pushB(HDR, 0); pushB(8'h02, 0);
      pushB(8'h11, 0); pushB(8'h22, 0); pushB(8'h33, 0); pushB(8'h44, 0);
      pushB(8'h55, 0); pushB(8'h66, 0);
      applyStimulus();
      checkOutput("pre-reset busy", 64'(busy), 64'd1);
      checkOutput("pre-reset words_loaded", 64'(words_loaded), 64'd1);
      checkOutput("pre-reset wdata", 64'(imem_wdata), 64'h11223344);
      @(negedge CCLK);
      #2 reset_n = 1'b0;
      #1 checkAllZero("async reset");
      @(negedge CCLK);
      reset_n = 1'b1;
      repeat (4) @(negedge CCLK);
      clearAll();
      pushB(8'h77, 0); pushB(8'h88, 0);
      pushB(HDR, 0); pushB(8'h01, 0);
      pushB(8'hAA, 0); pushB(8'hBB, 0); pushB(8'hCC, 0); pushB(8'hDD, 0);
      pushB(8'h00, 0);
      applyStimulus();
      compareWithModel("post-reset");

      // Full 256-word image: addresses 0..255 and a 9-bit word count of 256.
      clearAll();
      pushB(HDR, 0); pushB(8'h00, 0);
      x = 8'h00;
      for (int d = 0; d < 1024; d++) begin
         b = 8'($urandom_range(0, 255));
         pushB(b, 0);
         x = x ^ b;
      end
      pushB(x, 0);
      applyStimulus();
      compareWithModel("full");
      checkOutput("full words_loaded", 64'(words_loaded), 64'd256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
